// File: rtl/icache_param_if.sv
// Bundles the fetch side and the memory-arbiter side of icache_param.
// The cache uses the slave modport; the driver of both sides uses master.
interface icache_param_if #(
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iinvalidate;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic [31:0]       hitcount;
  logic [31:0]       misscount;

  modport slave (
    input  imemREN, imemaddr, iinvalidate, iwait, iload,
    output ihit, imemload, iREN, iaddr, hitcount, misscount
  );

  modport master (
    output imemREN, imemaddr, iinvalidate, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hitcount, misscount
  );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped instruction cache with multi-word lines filled by a sequential
// burst, whole-cache invalidate and saturating hit/miss counters.
module icache_param #(
  parameter int WORD_W = 32,
  parameter int IIDX_W = 4,
  parameter int IBLK_W = 1,
  parameter int IBYT_W = 2,
  parameter int ITAG_W = WORD_W - IIDX_W - IBLK_W - IBYT_W
) (
  input logic           CLK,
  input logic           RST,
  icache_param_if.slave bus
);
  localparam int NLINES = 1 << IIDX_W;
  localparam int NWORDS = 1 << IBLK_W;
  localparam int CNT_W  = (IBLK_W > 0) ? IBLK_W : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
  localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [NLINES-1:0] valid_r;
  logic [ITAG_W-1:0] tag_r  [NLINES];
  logic [WORD_W-1:0] data_r [NLINES][NWORDS];
  logic [ITAG_W-1:0] fill_tag_r;
  logic [IIDX_W-1:0] fill_idx_r;
  logic [CNT_W-1:0]  word_cnt_r;
  logic              kill_r;
  logic [31:0]       hit_cnt_r;
  logic [31:0]       miss_cnt_r;

  logic [ITAG_W-1:0] tag_s;
  logic [IIDX_W-1:0] idx_s;
  logic [CNT_W-1:0]  blk_s;
  logic [WORD_W-1:0] fill_addr_s;
  logic              lookup_hit_s;
  logic              miss_s;
  logic              accept_s;
  logic              last_s;
  logic              ihit_s;
  logic [WORD_W-1:0] imemload_s;
  logic              iren_s;
  logic [WORD_W-1:0] iaddr_s;
  logic              unused_byte_s;

  assign tag_s         = bus.imemaddr[WORD_W-1 -: ITAG_W];
  assign idx_s         = bus.imemaddr[IBYT_W+IBLK_W +: IIDX_W];
  assign unused_byte_s = ^bus.imemaddr[IBYT_W-1:0];

  // With one-word lines there is no offset field in either address.
  generate
    if (IBLK_W > 0) begin : g_blk
      assign blk_s       = bus.imemaddr[IBYT_W +: CNT_W];
      assign fill_addr_s = {fill_tag_r, fill_idx_r, word_cnt_r, {IBYT_W{1'b0}}};
    end else begin : g_noblk
      assign blk_s       = 1'b0;
      assign fill_addr_s = {fill_tag_r, fill_idx_r, {IBYT_W{1'b0}}};
    end
  endgenerate

  assign lookup_hit_s = (state_r == IDLE) & bus.imemREN & valid_r[idx_s]
                      & (tag_r[idx_s] == tag_s);
  assign miss_s       = (state_r == IDLE) & bus.imemREN & ~lookup_hit_s;
  assign accept_s     = (state_r == REFILL) & ~bus.iwait;
  assign last_s       = accept_s & (word_cnt_r == LAST_WORD);

  // Next-state and output decode; the hit path is combinational for zero-latency fetch.
  always_comb begin
    state_nxt_s = state_r;
    ihit_s      = 1'b0;
    imemload_s  = '0;
    iren_s      = 1'b0;
    iaddr_s     = '0;
    case (state_r)
      IDLE: begin
        ihit_s = lookup_hit_s;
        if (lookup_hit_s) begin
          imemload_s = data_r[idx_s][blk_s];
        end else begin
          imemload_s = '0;
        end
        if (miss_s) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REFILL: begin
        iren_s  = 1'b1;
        iaddr_s = fill_addr_s;
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign bus.ihit      = ihit_s;
  assign bus.imemload  = imemload_s;
  assign bus.iREN      = iren_s;
  assign bus.iaddr     = iaddr_s;
  assign bus.hitcount  = hit_cnt_r;
  assign bus.misscount = miss_cnt_r;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Refill target latch and burst word counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fill_tag_r <= '0;
      fill_idx_r <= '0;
      word_cnt_r <= '0;
    end else if (miss_s) begin
      fill_tag_r <= tag_s;
      fill_idx_r <= idx_s;
      word_cnt_r <= '0;
    end else if (accept_s) begin
      word_cnt_r <= word_cnt_r + CNT_W'(1);
    end
  end

  // Valid bits and kill flag; a mid-refill invalidate keeps the in-flight line invalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r <= '0;
      kill_r  <= 1'b0;
    end else begin
      if (bus.iinvalidate) begin
        valid_r <= '0;
      end else if (last_s && !kill_r) begin
        valid_r[fill_idx_r] <= 1'b1;
      end
      if (last_s) begin
        kill_r <= 1'b0;
      end else if ((state_r == REFILL) && bus.iinvalidate) begin
        kill_r <= 1'b1;
      end
    end
  end

  // Tag and data arrays: contents are qualified by valid, so they need no reset.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      data_r[fill_idx_r][word_cnt_r] <= bus.iload;
    end
    if (last_s) begin
      tag_r[fill_idx_r] <= fill_tag_r;
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (lookup_hit_s && (hit_cnt_r != CNT_MAX)) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_s && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param: table of IDLE lookups plus hand-written
// refill, conflict, invalidate and counter-saturation sequences.
module tb_icache_param;
  logic CLK = 1'b0;
  logic RST;

  icache_param_if #(.WORD_W(32)) bus ();

  icache_param #(
    .WORD_W(32),
    .IIDX_W(4),
    .IBLK_W(1),
    .IBYT_W(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [8];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] hit_exp  = 32'd0;
  logic [31:0] miss_exp = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hAAAA_0001;
    else if (a == 32'h0000_0044) return 32'hAAAA_0002;
    else return {16'hBBBB, a[15:0]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
    else passed++;
  endtask

  // One IDLE cycle presenting addr; checks outputs and counters before the edge.
  task automatic lookup(input string nm, input logic [31:0] addr, input logic exp_h,
                        input logic [31:0] exp_d, input logic inv);
    @(negedge CLK);
    bus.imemREN     = 1'b1;
    bus.imemaddr    = addr;
    bus.iinvalidate = inv;
    bus.iwait       = 1'b1;
    bus.iload       = 32'd0;
    #1;
    chk1({nm, "_ihit"}, bus.ihit, exp_h);
    chk({nm, "_imemload"}, bus.imemload, exp_h ? exp_d : 32'd0);
    chk1({nm, "_iREN"}, bus.iREN, 1'b0);
    chk({nm, "_hitcount"}, bus.hitcount, hit_exp);
    chk({nm, "_misscount"}, bus.misscount, miss_exp);
    if (exp_h) hit_exp = sat_inc(hit_exp);
    else miss_exp = sat_inc(miss_exp);
  endtask

  // Serve a two-word burst; fetch inputs wander to show the latched line is used.
  task automatic refill(input logic [31:0] base, input int waits, input int inval_at);
    int cyc;
    logic [31:0] a;
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      a = base + 32'(k * 4);
      for (int w = 0; w <= waits; w++) begin
        @(negedge CLK);
        cyc++;
        bus.imemREN     = 1'b0;
        bus.imemaddr    = 32'h0000_0F00;
        bus.iinvalidate = (cyc == inval_at);
        bus.iwait       = (w < waits);
        bus.iload       = (w < waits) ? 32'hDEAD_BEEF : mem_word(a);
        #1;
        chk1("refill_iREN", bus.iREN, 1'b1);
        chk("refill_iaddr", bus.iaddr, a);
        chk1("refill_ihit", bus.ihit, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0040, 1'b1, 32'hAAAA_0001};
    vecs[1] = '{1'b1, 32'h0000_0047, 1'b1, 32'hAAAA_0002};
    vecs[2] = '{1'b0, 32'h0000_0044, 1'b0, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_0104, 1'b1, 32'hBBBB_0104};
    vecs[4] = '{1'b1, 32'h0000_0100, 1'b1, 32'hBBBB_0100};
    vecs[5] = '{1'b1, 32'h0000_0041, 1'b1, 32'hAAAA_0001};
    vecs[6] = '{1'b0, 32'h0000_0100, 1'b0, 32'h0000_0000};
    vecs[7] = '{1'b1, 32'h0000_0106, 1'b1, 32'hBBBB_0104};

    RST             = 1'b1;
    bus.imemREN     = 1'b0;
    bus.imemaddr    = 32'd0;
    bus.iinvalidate = 1'b0;
    bus.iwait       = 1'b1;
    bus.iload       = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk1("reset_ihit", bus.ihit, 1'b0);
    chk1("reset_iREN", bus.iREN, 1'b0);
    chk("reset_iaddr", bus.iaddr, 32'd0);
    chk("reset_imemload", bus.imemload, 32'd0);
    chk("reset_hitcount", bus.hitcount, 32'd0);
    chk("reset_misscount", bus.misscount, 32'd0);

    // Cold miss and same-line hit.
    lookup("cold_miss", 32'h0000_0040, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0040, 0, 0);
    lookup("rehit_40", 32'h0000_0040, 1'b1, 32'hAAAA_0001, 1'b0);
    lookup("same_line_44", 32'h0000_0044, 1'b1, 32'hAAAA_0002, 1'b0);
    lookup("miss_100", 32'h0000_0100, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0100, 0, 0);

    // Table of IDLE lookups over the two resident lines.
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      bus.imemREN     = vecs[i].ren;
      bus.imemaddr    = vecs[i].addr;
      bus.iinvalidate = 1'b0;
      bus.iwait       = 1'b1;
      #1;
      chk1($sformatf("vec%0d_ihit", i), bus.ihit, vecs[i].exp_hit);
      chk($sformatf("vec%0d_imemload", i), bus.imemload, vecs[i].exp_data);
      chk1($sformatf("vec%0d_iREN", i), bus.iREN, 1'b0);
      chk($sformatf("vec%0d_hitcount", i), bus.hitcount, hit_exp);
      if (vecs[i].exp_hit) hit_exp = sat_inc(hit_exp);
    end

    // Conflict miss on idx 8 with wait states, then the evicted line misses.
    lookup("conflict_C0", 32'h0000_00C0, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_00C0, 3, 0);
    lookup("hit_C0", 32'h0000_00C0, 1'b1, 32'hBBBB_00C0, 1'b0);
    lookup("hit_C4", 32'h0000_00C4, 1'b1, 32'hBBBB_00C4, 1'b0);
    lookup("evicted_40", 32'h0000_0040, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0040, 0, 0);
    lookup("refetched_40", 32'h0000_0040, 1'b1, 32'hAAAA_0001, 1'b0);

    // Invalidate on the second refill cycle: line completes but stays invalid.
    lookup("miss_80", 32'h0000_0080, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0080, 1, 2);
    lookup("killed_80", 32'h0000_0080, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0080, 0, 0);
    lookup("inv_idle_hit_80", 32'h0000_0080, 1'b1, 32'hBBBB_0080, 1'b1);
    lookup("inv_and_miss_80", 32'h0000_0080, 1'b0, 32'd0, 1'b1);
    refill(32'h0000_0080, 0, 0);
    lookup("valid_after_inv_miss", 32'h0000_0084, 1'b1, 32'hBBBB_0084, 1'b0);
    lookup("cleared_40", 32'h0000_0040, 1'b0, 32'd0, 1'b0);
    refill(32'h0000_0040, 0, 0);

    // Hit counter saturation.
    @(negedge CLK);
    bus.imemREN     = 1'b0;
    bus.iinvalidate = 1'b0;
    force dut.hit_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_r;
    hit_exp = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      lookup("sat_hit", 32'h0000_0044, 1'b1, 32'hAAAA_0002, 1'b0);
    end
    @(negedge CLK);
    bus.imemREN = 1'b0;
    #1;
    chk("sat_hitcount", bus.hitcount, 32'hFFFF_FFFF);
    chk("final_misscount", bus.misscount, miss_exp);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised, direct-mapped instruction cache; successor to the fixed one-word-per-line icache.
- Configurable index width and block size (multi-word lines, 2^IBLK_W words), filled by sequential burst refill.
- Adds whole-cache invalidate and saturating hit/miss counters.
- Sits between fetch stage (imem* side) and memory arbiter (i* side).

Parameters:
- WORD_W, 32, data/address word width.
- IIDX_W, 4, index bits; 2^IIDX_W lines.
- IBLK_W, 1, block-offset bits; 2^IBLK_W words per line (0 legal = one-word lines).
- IBYT_W, 2, byte-offset bits.
- ITAG_W, WORD_W-IIDX_W-IBLK_W-IBYT_W, derived tag width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- imemREN  in  1  fetch request.
- imemaddr  in  WORD_W  fetch byte address.
- ihit  out  1  requested word valid this cycle.
- imemload  out  WORD_W  instruction word.
- iinvalidate  in  1  one-cycle pulse: clear all valid bits.
- iREN  out  1  memory read request.
- iaddr  out  WORD_W  memory read address.
- iwait  in  1  memory busy; data accepted when iREN=1 and iwait=0.
- iload  in  WORD_W  memory read data.
- hitcount  out  32  saturating hit counter.
- misscount  out  32  saturating miss counter.

Behaviour:
- Address split: {tag, idx, blkoff, bytoff} = imemaddr; bytoff ignored.
- Storage: per line, valid bit, ITAG_W tag, 2^IBLK_W words. Arrays are registers; no data reset needed.
- Reset (async): all valid = 0, state = IDLE, word counter = 0, counters = 0, iREN = 0, iaddr = 0, ihit = 0, imemload = 0.
- State IDLE:
  - Hit condition: imemREN & valid[idx] & tag match.
  - On hit: ihit = 1 combinationally in the same cycle; imemload = word[blkoff]. Zero-cycle latency.
  - On miss (imemREN & not hit): ihit = 0; latch tag/idx into refill registers; counter = 0; next state REFILL; misscount += 1 (once per miss).
  - No imemREN: ihit = 0, imemload = 0.
- State REFILL:
  - iREN = 1; iaddr = {latched tag, latched idx, counter, IBYT_W'b0}.
  - Each cycle iwait = 0: write iload into word[counter] of the latched line; counter += 1.
  - On accepting the last word (counter = 2^IBLK_W-1): write tag; set valid unless a kill flag is set; clear kill; return to IDLE.
  - ihit = 0 throughout REFILL.
- Re-lookup: the CPU re-presents the address, so it hits on the first IDLE cycle after refill.
- Refill is never aborted. Address changes or imemREN drop mid-refill do not affect the latched line.
- hitcount += 1 on every IDLE cycle with a hit.
- Counter saturation: both counters hold at 0xFFFF_FFFF; they do not wrap.
- iinvalidate:
  - Clears all valid bits at the edge, whatever the state.
  - If asserted during REFILL, sets kill, so the in-flight line completes without becoming valid.
  - If asserted in IDLE, the same-cycle lookup still uses pre-clear valid bits.
- Counter width is IBLK_W. When IBLK_W = 0, REFILL lasts exactly one accepted word.
- Simultaneous iinvalidate and miss in IDLE: both act; the refill proceeds and its line is valid at completion (kill not set, since REFILL not yet entered).

Test Plan:
- Reset: hold RST=1 for 2 cycles -> ihit=0, iREN=0, hitcount=misscount=0; every address misses afterward.
- Cold miss, defaults, imemaddr=0x0000_0040 (idx=8, blk=0) with iwait=0:
  - iREN=1 and iaddr=0x40 then 0x44 on consecutive cycles, iload=0xAAAA_0001/0xAAAA_0002.
  - Next cycle ihit=1, imemload=0xAAAA_0001; misscount=1.
- Same-line hit, after cold miss: imemaddr=0x44 -> ihit=1 same cycle, imemload=0xAAAA_0002, hitcount increments, iREN=0.
- Conflict plus wait states:
  - imemaddr=0x0000_00C0 (same idx 8, tag 1), iwait=1 for 3 cycles before each word -> iaddr holds 0xC0 until accepted, then 0xC4.
  - Afterwards 0x40 misses again.
- Invalidate during REFILL: pulse iinvalidate on second refill cycle -> refill completes (2 words fetched), yet re-lookup misses and a new refill starts.
- Counter saturation: force hitcount to 0xFFFF_FFFE, perform 3 hits -> hitcount=0xFFFF_FFFF.
